// File: rtl/fwd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fwd_pkg
// Description : Shared types and helpers for the forwarding / hazard unit.
//               - stage_entry_t : one shadow-pipeline slot
//               - FWD_RF        : forward-select code meaning "use register file"
//               - sel_width()   : width of a forward-select field for DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
package fwd_pkg;

  // Storage width of the destination field in a shadow entry. Callers
  // zero-extend their ADDR_W-bit addresses into it, so ADDR_W must not
  // exceed this value.
  localparam int RD_MAX_W = 8;

  // Forward-select code for "no producer in flight, read the register file".
  localparam int FWD_RF = 0;

  typedef struct packed {
    logic                valid;
    logic [RD_MAX_W-1:0] rd;
    logic                regwrite;
    logic                is_load;
  } stage_entry_t;

  // Codes 0..depth must be representable; never narrower than one bit.
  function automatic int sel_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_match.sv
`default_nettype none
// ============================================================================
// Module      : fwd_match
// Description : Compares one ID-stage source operand against every shadow
//               entry and returns the forward select of the youngest
//               matching producer, plus a flag when that producer is a load
//               whose data is not yet available.
// Ports       : entries     in  DEPTH shadow entries (0 = youngest / EX)
//               src_addr    in  source register address
//               src_used    in  operand is actually read
//               sel         out 0 = register file, k = entry k-1
//               load_hazard out selected producer is an unready load
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_match
  import fwd_pkg::*;
#(
  parameter int DEPTH      = 3,
  parameter int ADDR_W     = 5,
  parameter int ZERO_REG   = 31,
  parameter int LOAD_READY = 1,
  parameter int SEL_W      = sel_width(DEPTH)
) (
  input  stage_entry_t [DEPTH-1:0] entries,
  input  logic [ADDR_W-1:0]        src_addr,
  input  logic                     src_used,
  output logic [SEL_W-1:0]         sel,
  output logic                     load_hazard
);

  logic [RD_MAX_W-1:0] src_ext;
  logic                src_live;

  assign src_ext  = RD_MAX_W'(src_addr);
  // A match requires rd == src, so excluding the zero register on the
  // source side also excludes it on every entry.
  assign src_live = src_used & (src_ext != RD_MAX_W'(ZERO_REG));

  // Scan oldest to youngest so the youngest match is the one left standing.
  // The hazard flag follows the selected entry only, so an older ready
  // producer can never hide a younger unready load.
  always_comb begin
    sel         = SEL_W'(FWD_RF);
    load_hazard = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (src_live && entries[i].valid && entries[i].regwrite &&
          (entries[i].rd == src_ext)) begin
        sel         = SEL_W'(i + 1);
        load_hazard = entries[i].is_load && (i < LOAD_READY);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : fwd_hazard_unit
// Description : Forwarding and hazard unit beside the ID stage. Keeps a
//               DEPTH-entry shadow record of in-flight destinations, drives
//               per-operand forward selects (youngest producer wins) and
//               raises load-use / memory-wait stalls.
// Ports       : clk, reset_n         clock, async active-low reset
//               issue_valid/rd/regwrite/is_load  ID instruction fields
//               src_addr, src_used   ID source operands
//               flush                kill the ID instruction
//               mem_busy             freeze the whole pipeline
//               fwd_sel              per-operand forward select
//               stall                hold PC and IF/ID
//               stall_count          saturating stalled-cycle counter
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int NUM_SRC    = 3,
  parameter int DEPTH      = 3,
  parameter int ADDR_W     = 5,
  parameter int ZERO_REG   = 31,
  parameter int LOAD_READY = 1
) (
  input  logic                                        clk,
  input  logic                                        reset_n,
  input  logic                                        issue_valid,
  input  logic [ADDR_W-1:0]                           issue_rd,
  input  logic                                        issue_regwrite,
  input  logic                                        issue_is_load,
  input  logic [NUM_SRC-1:0][ADDR_W-1:0]              src_addr,
  input  logic [NUM_SRC-1:0]                          src_used,
  input  logic                                        flush,
  input  logic                                        mem_busy,
  output logic [NUM_SRC-1:0][sel_width(DEPTH)-1:0]    fwd_sel,
  output logic                                        stall,
  output logic [15:0]                                 stall_count
);

  localparam int          SEL_W   = sel_width(DEPTH);
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  stage_entry_t [DEPTH-1:0] entries_q;
  stage_entry_t [DEPTH-1:0] entries_d;
  logic [15:0]              stall_count_q;
  logic [15:0]              stall_count_d;

  logic [NUM_SRC-1:0]       hazard_vec;
  logic                     load_stall;

  // --------------------------------------------------------------------------
  // Per-operand match / priority logic
  // --------------------------------------------------------------------------
  generate
    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
      fwd_match #(
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W),
        .ZERO_REG   (ZERO_REG),
        .LOAD_READY (LOAD_READY),
        .SEL_W      (SEL_W)
      ) u_match (
        .entries     (entries_q),
        .src_addr    (src_addr[s]),
        .src_used    (src_used[s]),
        .sel         (fwd_sel[s]),
        .load_hazard (hazard_vec[s])
      );
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Stall combine: a flushed or empty ID slot cannot cause a load-use stall,
  // but a busy memory freezes everything regardless.
  // --------------------------------------------------------------------------
  always_comb begin
    load_stall = (|hazard_vec) & issue_valid & ~flush;
    stall      = mem_busy | load_stall;
  end

  // --------------------------------------------------------------------------
  // Shadow pipeline next state
  // --------------------------------------------------------------------------
  always_comb begin
    entries_d = entries_q;
    if (!mem_busy) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        entries_d[i] = entries_q[i-1];
      end
      // Load-use stall keeps the consumer in ID, so EX receives a bubble.
      entries_d[0] = '0;
      if (!load_stall) begin
        entries_d[0].valid    = issue_valid & ~flush;
        entries_d[0].rd       = RD_MAX_W'(issue_rd);
        entries_d[0].regwrite = issue_regwrite;
        entries_d[0].is_load  = issue_is_load;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Saturating stall counter
  // --------------------------------------------------------------------------
  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != CNT_MAX)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      entries_q     <= '0;
      stall_count_q <= '0;
    end else begin
      entries_q     <= entries_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fwd_hazard_unit
// Description : Self-checking bench for fwd_hazard_unit (default parameters).
//               A list-style reference model tracks in-flight producers and
//               is compared against the DUT every cycle; directed sequences
//               add hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fwd_hazard_unit;

  localparam int NS = 3;
  localparam int DP = 3;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                issue_valid;
  logic [4:0]          issue_rd;
  logic                issue_regwrite;
  logic                issue_is_load;
  logic [NS-1:0][4:0]  src_addr;
  logic [NS-1:0]       src_used;
  logic                flush;
  logic                mem_busy;
  logic [NS-1:0][1:0]  fwd_sel;
  logic                stall;
  logic [15:0]         stall_count;

  int total = 0;
  int bad   = 0;

  fwd_hazard_unit dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .issue_valid    (issue_valid),
    .issue_rd       (issue_rd),
    .issue_regwrite (issue_regwrite),
    .issue_is_load  (issue_is_load),
    .src_addr       (src_addr),
    .src_used       (src_used),
    .flush          (flush),
    .mem_busy       (mem_busy),
    .fwd_sel        (fwd_sel),
    .stall          (stall),
    .stall_count    (stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: slot 0 is the most recent issue, slot DP-1 the oldest.
  // --------------------------------------------------------------------------
  bit       m_v  [DP];
  bit [4:0] m_rd [DP];
  bit       m_rw [DP];
  bit       m_ld [DP];
  int       m_cnt = 0;

  // Youngest producer of the register read by operand s, as a 1-based age.
  function automatic int exp_sel(input int s);
    if (!src_used[s] || src_addr[s] == 5'd31) return 0;
    for (int i = 0; i < DP; i++)
      if (m_v[i] && m_rw[i] && m_rd[i] == src_addr[s]) return i + 1;
    return 0;
  endfunction

  function automatic bit exp_stall();
    bit h = 0;
    for (int s = 0; s < NS; s++) begin
      int k = exp_sel(s);
      if (k == 1 && m_ld[0]) h = 1;  // only the EX slot is too young
    end
    return mem_busy || (h && issue_valid && !flush);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DP; i++) m_v[i] <= 1'b0;
      m_cnt <= 0;
    end else begin
      if (exp_stall() && m_cnt < 65535) m_cnt <= m_cnt + 1;
      if (!mem_busy) begin
        for (int i = 1; i < DP; i++) begin
          m_v[i] <= m_v[i-1]; m_rd[i] <= m_rd[i-1];
          m_rw[i] <= m_rw[i-1]; m_ld[i] <= m_ld[i-1];
        end
        m_v[0]  <= exp_stall() ? 1'b0 : (issue_valid && !flush);
        m_rd[0] <= issue_rd;
        m_rw[0] <= issue_regwrite;
        m_ld[0] <= issue_is_load;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    for (int s = 0; s < NS; s++)
      check($sformatf("model_sel%0d", s), 32'(fwd_sel[s]), 32'(exp_sel(s)));
    check("model_stall", 32'(stall), 32'(exp_stall()));
    check("model_count", 32'(stall_count), 32'(m_cnt));
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  task automatic drive(input bit v, input int rd, input bit rw, input bit ld,
                       input int a0, input int a1, input int a2, input bit [2:0] used,
                       input bit fl = 1'b0, input bit mb = 1'b0);
    @(posedge clk); #1;
    issue_valid = v; issue_rd = 5'(rd); issue_regwrite = rw; issue_is_load = ld;
    src_addr[0] = 5'(a0); src_addr[1] = 5'(a1); src_addr[2] = 5'(a2);
    src_used = used; flush = fl; mem_busy = mb;
    #1;
  endtask

  task automatic nop(input bit mb = 1'b0);
    drive(1'b0, 0, 1'b0, 1'b0, 0, 0, 0, 3'b000, 1'b0, mb);
  endtask

  initial begin
    reset_n = 1'b0; issue_valid = 0; issue_rd = 0; issue_regwrite = 0;
    issue_is_load = 0; src_addr = '0; src_used = '0; flush = 0; mem_busy = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_sel", 32'(fwd_sel), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_count", 32'(stall_count), 32'd0);
    reset_n = 1'b1;

    // Back-to-back ALU: ADD X1,X2,X3 ; SUB X2,X1,X3
    drive(1, 1, 1, 0, 2, 3, 0, 3'b011);
    drive(1, 2, 1, 0, 1, 3, 0, 3'b011);
    check("b2b_sel0", 32'(fwd_sel[0]), 32'd1);
    check("b2b_stall", 32'(stall), 32'd0);

    // One bubble between producer and consumer
    drive(1, 6, 1, 0, 2, 3, 0, 3'b011);
    nop();
    drive(1, 7, 1, 0, 6, 3, 0, 3'b011);
    check("bubble_sel0", 32'(fwd_sel[0]), 32'd2);

    // Same rd in entries 0 and 1: youngest wins
    drive(1, 5, 1, 0, 2, 3, 0, 3'b011);
    drive(1, 5, 1, 0, 2, 3, 0, 3'b011);
    drive(1, 8, 1, 0, 3, 5, 0, 3'b011);
    check("youngest_sel1", 32'(fwd_sel[1]), 32'd1);

    // Load-use: LDUR X4 ; ADD X10,X4,X3
    drive(1, 4, 1, 1, 2, 0, 0, 3'b001);
    drive(1, 10, 1, 0, 4, 3, 0, 3'b011);
    check("lu_stall", 32'(stall), 32'd1);
    check("lu_sel_during", 32'(fwd_sel[0]), 32'd1);
    drive(1, 10, 1, 0, 4, 3, 0, 3'b011);
    check("lu_stall_after", 32'(stall), 32'd0);
    check("lu_sel_after", 32'(fwd_sel[0]), 32'd2);
    check("lu_count", 32'(stall_count), 32'd1);

    // Zero register never forwards (even from a load)
    drive(1, 31, 1, 1, 0, 0, 0, 3'b000);
    drive(1, 31, 1, 0, 0, 0, 0, 3'b000);
    drive(1, 31, 1, 1, 0, 0, 0, 3'b000);
    drive(1, 12, 1, 0, 31, 31, 31, 3'b111);
    check("zero_sel", 32'(fwd_sel), 32'd0);
    check("zero_stall", 32'(stall), 32'd0);

    // Unused operand with a live match
    drive(1, 7, 1, 0, 2, 3, 0, 3'b011);
    drive(1, 9, 1, 0, 7, 7, 7, 3'b000);
    check("unused_sel", 32'(fwd_sel), 32'd0);

    // Load hazard under a 3-cycle freeze, then async reset mid-freeze
    drive(1, 8, 1, 1, 2, 0, 0, 3'b001);
    drive(1, 11, 1, 0, 8, 0, 0, 3'b001, 1'b0, 1'b1);
    check("frz_stall0", 32'(stall), 32'd1);
    drive(1, 11, 1, 0, 8, 0, 0, 3'b001, 1'b0, 1'b1);
    check("frz_stall1", 32'(stall), 32'd1);
    check("frz_sel_held", 32'(fwd_sel[0]), 32'd1);
    drive(1, 11, 1, 0, 8, 0, 0, 3'b001, 1'b0, 1'b1);
    check("frz_stall2", 32'(stall), 32'd1);
    check("frz_count", 32'(stall_count), 32'd3);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("rstmid_stall", 32'(stall), 32'd1);
    check("rstmid_sel", 32'(fwd_sel), 32'd0);
    check("rstmid_count", 32'(stall_count), 32'd0);
    drive(1, 11, 1, 0, 8, 0, 0, 3'b001);
    reset_n = 1'b1;
    #1;
    check("rstrel_stall", 32'(stall), 32'd0);
    check("rstrel_count", 32'(stall_count), 32'd0);

    // Load hazard with flush in the same cycle: flush wins
    drive(1, 9, 1, 1, 2, 0, 0, 3'b001);
    drive(1, 9, 1, 0, 9, 9, 0, 3'b011, 1'b1);
    check("flush_stall", 32'(stall), 32'd0);
    drive(1, 13, 1, 0, 9, 0, 0, 3'b001);
    check("flush_sel", 32'(fwd_sel[0]), 32'd2);
    check("flush_count", 32'(stall_count), 32'd0);

    // Saturation of the stall counter
    nop(1'b1);
    repeat (65540) @(posedge clk);
    #2;
    check("sat_count", 32'(stall_count), 32'hFFFF);
    nop();
    check("sat_hold", 32'(stall_count), 32'hFFFF);
    check("sat_stall_off", 32'(stall), 32'd0);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
